// File: rtl/uart_frame_arbiter_if.sv
// Bundle between the two sample requesters, the uart_tx instance and the
// frame arbiter. The slave modport is the arbiter; the master modport is the
// environment around it (requesters plus transmitter busy).
interface uart_frame_arbiter_if;
    logic        req_a;
    logic [11:0] data_a;
    logic        ack_a;
    logic        req_b;
    logic [11:0] data_b;
    logic        ack_b;
    logic        uart_tx_busy;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        frame_active;
    logic [15:0] frame_cnt;

    modport master (
        output req_a, data_a, req_b, data_b, uart_tx_busy,
        input  ack_a, ack_b, uart_tx_en, uart_tx_data, frame_active, frame_cnt
    );

    modport slave (
        input  req_a, data_a, req_b, data_b, uart_tx_busy,
        output ack_a, ack_b, uart_tx_en, uart_tx_data, frame_active, frame_cnt
    );
endinterface

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that turns 12-bit samples from two channels into
// 4-byte checksummed frames (header, ch/high nibble, low byte, xor) and
// feeds them byte by byte to a shared uart_tx. Frames never interleave; a
// byte whose busy response never shows up is re-strobed after BUSY_TO cycles.
module uart_frame_arbiter #(
    parameter logic [7:0]  HEADER  = 8'hA5,
    parameter int unsigned BUSY_TO = 4
) (
    input logic                 clk,
    input logic                 resetn,
    uart_frame_arbiter_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_SEND,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    localparam logic [3:0] BUSY_TO_W = 4'(BUSY_TO);
    localparam logic       CH_B      = 1'b1;

    state_t      state_q,        state_d;
    logic        grant_ch_q,     grant_ch_d;
    logic        last_grant_q,   last_grant_d;
    logic [11:0] sample_q,       sample_d;
    logic [1:0]  byte_idx_q,     byte_idx_d;
    logic [3:0]  to_cnt_q,       to_cnt_d;
    logic        ack_a_q,        ack_a_d;
    logic        ack_b_q,        ack_b_d;
    logic        tx_en_q,        tx_en_d;
    logic [7:0]  tx_data_q,      tx_data_d;
    logic        frame_active_q, frame_active_d;
    logic [15:0] frame_cnt_q,    frame_cnt_d;

    logic        any_req;
    logic        winner;
    logic [7:0]  b1;
    logic [7:0]  b2;
    logic [7:0]  b3;
    logic [7:0]  frame_byte;

    // Pick the requester: a lone requester wins, a tie goes to the channel not served last.
    always_comb begin
        any_req = bus.req_a | bus.req_b;
        if (bus.req_a && bus.req_b) begin
            winner = ~last_grant_q;
        end else begin
            winner = bus.req_b;
        end
    end

    // Assemble the byte selected by byte_idx from the captured sample.
    always_comb begin
        b1         = {3'b000, grant_ch_q, sample_q[11:8]};
        b2         = sample_q[7:0];
        b3         = HEADER ^ b1 ^ b2;
        frame_byte = HEADER;
        case (byte_idx_q)
            2'd0:    frame_byte = HEADER;
            2'd1:    frame_byte = b1;
            2'd2:    frame_byte = b2;
            default: frame_byte = b3;
        endcase
    end

    // Next-state and registered-output logic for the framing FSM.
    always_comb begin
        // NOTE: every _d gets a hold/idle default before the case so no path leaves it unassigned (no latches).
        state_d        = state_q;
        grant_ch_d     = grant_ch_q;
        last_grant_d   = last_grant_q;
        sample_d       = sample_q;
        byte_idx_d     = byte_idx_q;
        to_cnt_d       = to_cnt_q;
        ack_a_d        = 1'b0;
        ack_b_d        = 1'b0;
        tx_en_d        = 1'b0;
        tx_data_d      = tx_data_q;
        frame_active_d = frame_active_q;
        frame_cnt_d    = frame_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    grant_ch_d = winner;
                    state_d    = S_GRANT;
                end
            end

            S_GRANT: begin
                if (grant_ch_q == CH_B) begin
                    ack_b_d  = 1'b1;
                    sample_d = bus.data_b;
                end else begin
                    ack_a_d  = 1'b1;
                    sample_d = bus.data_a;
                end
                last_grant_d   = grant_ch_q;
                byte_idx_d     = 2'd0;
                frame_active_d = 1'b1;
                state_d        = S_SEND;
            end

            S_SEND: begin
                if (!bus.uart_tx_busy) begin
                    tx_en_d   = 1'b1;
                    tx_data_d = frame_byte;
                    to_cnt_d  = 4'd0;
                    state_d   = S_WAIT_BUSY;
                end
            end

            S_WAIT_BUSY: begin
                if (bus.uart_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 4'd1;
                    if (to_cnt_q + 4'd1 == BUSY_TO_W) begin
                        state_d = S_SEND;
                    end
                end
            end

            S_WAIT_DONE: begin
                if (!bus.uart_tx_busy) begin
                    if (byte_idx_q != 2'd3) begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = S_SEND;
                    end else begin
                        frame_cnt_d    = frame_cnt_q + 16'd1;
                        frame_active_d = 1'b0;
                        // Pending requests are judged on this same edge so the
                        // next frame starts two cycles after the final busy fall.
                        if (any_req) begin
                            grant_ch_d = winner;
                            state_d    = S_GRANT;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!resetn) begin
            // NOTE: every register here is small control/data state, so all of it is reset; a partial frame is dropped.
            state_q        <= S_IDLE;
            grant_ch_q     <= 1'b0;
            last_grant_q   <= CH_B;
            sample_q       <= 12'h000;
            byte_idx_q     <= 2'd0;
            to_cnt_q       <= 4'd0;
            ack_a_q        <= 1'b0;
            ack_b_q        <= 1'b0;
            tx_en_q        <= 1'b0;
            tx_data_q      <= 8'h00;
            frame_active_q <= 1'b0;
            frame_cnt_q    <= 16'h0000;
        end else begin
            state_q        <= state_d;
            grant_ch_q     <= grant_ch_d;
            last_grant_q   <= last_grant_d;
            sample_q       <= sample_d;
            byte_idx_q     <= byte_idx_d;
            to_cnt_q       <= to_cnt_d;
            ack_a_q        <= ack_a_d;
            ack_b_q        <= ack_b_d;
            tx_en_q        <= tx_en_d;
            tx_data_q      <= tx_data_d;
            frame_active_q <= frame_active_d;
            frame_cnt_q    <= frame_cnt_d;
        end
    end

    assign bus.ack_a        = ack_a_q;
    assign bus.ack_b        = ack_b_q;
    assign bus.uart_tx_en   = tx_en_q;
    assign bus.uart_tx_data = tx_data_q;
    assign bus.frame_active = frame_active_q;
    assign bus.frame_cnt    = frame_cnt_q;

endmodule

// File: doc/uart_frame_arbiter.md
# uart_frame_arbiter

Sequences the shared 8-bit UART transmitter between two 12-bit sample requesters (channel A, channel B). Each granted sample becomes a 4-byte frame: header, channel/high nibble, low byte, checksum. Frames never interleave. The block sits between the sample sources and the `uart_tx` instance. It replaces ad-hoc byte-splitting control with a framed, checksummed, round-robin stream.

## Interface
- `HEADER`, default 8'hA5: frame sync byte.
- `BUSY_TO`, default 4: max cycles to wait for `uart_tx_busy` to rise after `uart_tx_en` before the byte is retried; range 2..15.
- `clk` in 1: system clock. All logic is on the rising edge.
- `resetn` in 1: reset is synchronous and active-low.
- `req_a` in 1: channel A has a sample pending. Level signal, held until `ack_a`.
- `data_a` in 12: channel A sample. Must be stable while `req_a`=1.
- `ack_a` out 1: one-cycle pulse; `data_a` captured this cycle.
- `req_b`, `data_b`, `ack_b`: same as channel A, for channel B.
- `uart_tx_busy` in 1: transmitter busy, from `uart_tx`.
- `uart_tx_en` out 1: one-cycle byte-load strobe to `uart_tx`.
- `uart_tx_data` out 8: byte to transmit.
- `frame_active` out 1: high from grant until the last byte's busy falls.
- `frame_cnt` out 16: count of completed frames. Wraps 16'hFFFF -> 0.

## Operation
- States: IDLE, GRANT, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: if `req_a` or `req_b` is high -> GRANT.
  - Single requester: that requester wins.
  - Both requesting: the channel not granted last wins (round-robin, `last_grant` bit).
- GRANT (1 cycle):
  - Pulse the winner's `ack_*`.
  - Capture its data into `sample[11:0]` and record the channel id `ch` (A=0, B=1).
  - Update `last_grant`, set `byte_idx`=0, assert `frame_active` -> SEND.
- Frame bytes, in order:
  - b0 = `HEADER`.
  - b1 = {3'b000, `ch`, `sample[11:8]`}.
  - b2 = `sample[7:0]`.
  - b3 = b0 ^ b1 ^ b2.
- SEND: waits while `uart_tx_busy`=1. When busy=0, drives `uart_tx_en`=1 for one cycle with `uart_tx_data`=b[`byte_idx`], clears the timeout counter -> WAIT_BUSY.
- WAIT_BUSY:
  - busy=1 -> WAIT_DONE.
  - Otherwise increment the timeout counter. When it reaches `BUSY_TO` -> SEND with the same `byte_idx` (retry).
- WAIT_DONE: on busy=0:
  - If `byte_idx`<3: increment it -> SEND.
  - If `byte_idx`=3: increment `frame_cnt`, deassert `frame_active` -> IDLE.
- `uart_tx_data` holds its value from the `uart_tx_en` cycle until the next load. It is not cleared between bytes.
- Requests arriving mid-frame are not acknowledged until the block returns to IDLE.
- A request that drops before ack is simply not served; no error is flagged.
- Reset (`resetn`=0 at any edge, including mid-frame):
  - State IDLE, `last_grant`=B (so A wins the first tie), `byte_idx`=0.
  - The partial frame is abandoned; no ack is generated.
  - The transmitter may finish its current byte; SEND waits for busy=0 as usual.

## Timing
- Reset values: `ack_a`=0, `ack_b`=0, `uart_tx_en`=0, `uart_tx_data`=8'h00, `frame_active`=0, `frame_cnt`=0.
- All outputs are registered.
- Request sampled high in IDLE at edge N -> `ack_*` and `frame_active` high after edge N+1 -> first `uart_tx_en` after edge N+2, if busy=0.
- `uart_tx_en` is never high on two consecutive cycles.
- `uart_tx_en` is never asserted while `uart_tx_busy`=1.
- Busy falls on the last byte at edge M -> `frame_cnt` increments and `frame_active` falls after edge M+1. The next request is sampled at M+1, so the next ack follows after M+2.
- Back-to-back frames: the next frame starts 2 cycles after the previous frame's final busy-fall.
- `frame_cnt` increments exactly once per completed 4-byte frame. Retries and abandoned frames do not count.

## Test plan
- Single A frame: `req_a`=1, `data_a`=12'h3C7 -> one `ack_a` pulse; bytes A5, 03, C7, 61 in order; `frame_cnt` 0 -> 1; `frame_active` falls.
- Simultaneous requests after reset: `req_a`=`req_b`=1, `data_a`=12'h123, `data_b`=12'hFFF -> A frame (A5, 01, 23, 87) then B frame (A5, 1F, FF, 45); `frame_cnt`=2.
- Fairness: both channels requesting continuously for 6 frames -> grants alternate A, B, A, B, A, B; ack pulses never coincide.
- Busy stall: hold `uart_tx_busy`=1 for 100 cycles before the first byte -> no `uart_tx_en` until busy falls; then exactly one strobe with 8'hA5.
- Timeout retry: suppress the busy response to the second strobe -> after `BUSY_TO`=4 cycles, b1 is re-strobed with the same value; frame completes; `frame_cnt` increments by 1 only.
- Reset mid-frame: assert `resetn`=0 during b2 -> all outputs return to reset values next edge; after release with `req_b` pending, a new B frame starts with b0=A5; `frame_cnt`=0.
